nor_gate: RTL and testbench

NOR_GATE -- requirements
Module: nor_gate

---
 rtl/nor_gate_pkg.sv | 7 +
 rtl/nor2_cell.sv | 10 +
 rtl/nor_gate.sv | 80 ++++++++
 tb/tb_nor_gate.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/nor_gate_pkg.sv
// Shared defaults for the NOR-gate block.
package nor_gate_pkg;

    localparam int unsigned REGISTER_OUT_DEFAULT = 1;
    localparam int unsigned CNT_W_DEFAULT        = 8;

endpackage : nor_gate_pkg

// File: rtl/nor2_cell.sv
// Two-input NOR primitive; every gate in the datapath is one of these.
module nor2_cell (
    input  logic x,
    input  logic y,
    output logic z
);

    assign z = ~(x | y);

endmodule : nor2_cell

// File: rtl/nor_gate.sv
// NOR-only logic producing f3 = NOR(a,b,c) and f4 = (a|b)&~c, with an
// optional output register stage and a saturating f3 event counter.
module nor_gate
    import nor_gate_pkg::*;
#(
    parameter int unsigned REGISTER_OUT = REGISTER_OUT_DEFAULT,
    parameter int unsigned CNT_W        = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             f3,
    output logic             f4,
    output logic             out_valid,
    output logic [CNT_W-1:0] f3_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic nor_ab;
    logic or_ab;
    logic f3_c;
    logic f4_c;
    logic [CNT_W-1:0] cnt_q;

    // NOR(a,b) is shared by both outputs
    nor2_cell u_nor_ab (.x(a),      .y(b),      .z(nor_ab));
    // Self-NOR acts as an inverter, recovering a|b
    nor2_cell u_or_ab  (.x(nor_ab), .y(nor_ab), .z(or_ab));
    // f3 = NOR(a|b, c)
    nor2_cell u_f3     (.x(or_ab),  .y(c),      .z(f3_c));
    // f4 = NOR(NOR(a,b), c)
    nor2_cell u_f4     (.x(nor_ab), .y(c),      .z(f4_c));

    // Saturating count of accepted input sets with f3 = 1
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (in_valid && f3_c && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign f3_count = cnt_q;

    generate
        if (REGISTER_OUT != 0) begin : g_reg
            logic f3_q;
            logic f4_q;
            logic valid_q;

            // Capture results on valid edges; hold data and drop valid otherwise
            always_ff @(posedge clk) begin
                if (rst) begin
                    f3_q    <= 1'b0;
                    f4_q    <= 1'b0;
                    valid_q <= 1'b0;
                end else if (in_valid) begin
                    f3_q    <= f3_c;
                    f4_q    <= f4_c;
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end

            assign f3        = f3_q;
            assign f4        = f4_q;
            assign out_valid = valid_q;
        end else begin : g_comb
            assign f3        = f3_c;
            assign f4        = f4_c;
            assign out_valid = in_valid;
        end
    endgenerate

endmodule : nor_gate

// File: tb/tb_nor_gate.sv
// Self-checking bench: registered and combinational instances driven in
// parallel, registered results checked through an expected-value queue.
module tb_nor_gate;

    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic             f3;
        logic             f4;
        logic             ov;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic a;
    logic b;
    logic c;

    logic             rf3, rf4, rov;
    logic [CNT_W-1:0] rcnt;
    logic             cf3, cf4, cov;
    logic [CNT_W-1:0] ccnt;

    int tests = 0;
    int fails = 0;

    exp_t sb[$];

    // Model state after the most recent edge
    logic             m_f3  = 1'b0;
    logic             m_f4  = 1'b0;
    logic             m_ov  = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;

    always #5 clk = ~clk;

    nor_gate #(.REGISTER_OUT(1), .CNT_W(CNT_W)) u_reg (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
        .f3(rf3), .f4(rf4), .out_valid(rov), .f3_count(rcnt)
    );

    nor_gate #(.REGISTER_OUT(0), .CNT_W(CNT_W)) u_cmb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
        .f3(cf3), .f4(cf4), .out_valid(cov), .f3_count(ccnt)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkc(input string tag, input logic [CNT_W-1:0] obs,
                        input logic [CNT_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, check the combinational instance before the
    // edge, then pop the expected registered result after the edge.
    task automatic step(input logic r, input logic v,
                        input logic ia, input logic ib, input logic ic);
        exp_t e;
        logic ef3;
        logic ef4;
        rst      = r;
        in_valid = v;
        a        = ia;
        b        = ib;
        c        = ic;
        ef3 = ~(ia | ib | ic);
        ef4 = (ia | ib) & ~ic;
        #1;
        chk1("cmb_f3", cf3, ef3);
        chk1("cmb_f4", cf4, ef4);
        chk1("cmb_valid", cov, v);

        if (r) begin
            m_f3  = 1'b0;
            m_f4  = 1'b0;
            m_ov  = 1'b0;
            m_cnt = '0;
        end else if (v) begin
            m_f3 = ef3;
            m_f4 = ef4;
            m_ov = 1'b1;
            if (ef3 && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + CNT_W'(1);
        end else begin
            m_ov = 1'b0;
        end
        e.f3  = m_f3;
        e.f4  = m_f4;
        e.ov  = m_ov;
        e.cnt = m_cnt;
        sb.push_back(e);

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk1("reg_f3", rf3, e.f3);
            chk1("reg_f4", rf4, e.f4);
            chk1("reg_valid", rov, e.ov);
            chkc("reg_count", rcnt, e.cnt);
            chkc("cmb_count", ccnt, e.cnt);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk1("reset_f3", rf3, 1'b0);
        chkc("reset_count", rcnt, 8'd0);

        // Full truth table with in_valid held high
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v3;
            v3 = 3'(i);
            step(1'b0, 1'b1, v3[2], v3[1], v3[0]);
        end
        chkc("tt_count", rcnt, 8'd1);

        // Register 010, then idle with 000: data holds, valid drops, no count
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk1("hold_f4", rf4, 1'b1);
        chk1("hold_f3", rf3, 1'b0);
        chk1("hold_valid", rov, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chkc("hold_count", rcnt, 8'd1);

        // Reset wins over a valid 000 at the same edge
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk1("rst_pri_f3", rf3, 1'b0);
        chk1("rst_pri_valid", rov, 1'b0);
        chkc("rst_pri_count", rcnt, 8'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk1("resume_f3", rf3, 1'b1);
        chkc("resume_count", rcnt, 8'd1);

        // Saturation: 300 valid 000 sets
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chkc("sat_reg_count", rcnt, 8'd255);
        chkc("sat_cmb_count", ccnt, 8'd255);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chkc("sat_stay", rcnt, 8'd255);

        // Mid-stream reset, then resume
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chkc("mid_rst_count", rcnt, 8'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chkc("mid_resume_count", rcnt, 8'd1);
        chk1("mid_resume_f3", rf3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_nor_gate
